// File: rtl/epochtv1_pkg.sv
// Shared constants and types for the Epoch TV-1 CPU-side bus models.
// Holds the state-image layout and the loader / strobe state encodings.
// No logic; consumed via import epochtv1_pkg::*.
package epochtv1_pkg;

    // Layout of the 0x1404-byte state image (chip-relative addresses)
    localparam logic [12:0] VRAM_BASE  = 13'h0000;
    localparam logic [12:0] BGM_BASE   = 13'h1000;
    localparam logic [12:0] OAM_BASE   = 13'h1200;
    localparam logic [12:0] IOREG_BASE = 13'h1400;
    localparam logic [12:0] IMAGE_LEN  = 13'h1404;

    // Loader sequencing: wait for START, fetch a byte, arm the bus, strobe it
    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_FETCH  = 2'd1,
        LD_ARM    = 2'd2,
        LD_STROBE = 2'd3
    } ld_state_e;

    // Bus write-cycle generator: idle or holding WRB/CSB low
    typedef enum logic {
        BS_IDLE   = 1'b0,
        BS_STROBE = 1'b1
    } bs_state_e;

    // Which part of the image an address falls in
    typedef enum logic [1:0] {
        REGION_VRAM  = 2'd0,
        REGION_BGM   = 2'd1,
        REGION_OAM   = 2'd2,
        REGION_IOREG = 2'd3
    } region_e;

    // Chip address of image byte idx; 13-bit add wraps modulo 8192 by design
    function automatic logic [12:0] image_addr(input logic [12:0] base,
                                               input logic [12:0] idx);
        return base + idx;
    endfunction

    // Classify an image offset into its region (useful for debug views)
    function automatic region_e image_region(input logic [12:0] off);
        if (off >= IOREG_BASE)     return REGION_IOREG;
        else if (off >= OAM_BASE)  return REGION_OAM;
        else if (off >= BGM_BASE)  return REGION_BGM;
        else if (off >= VRAM_BASE) return REGION_VRAM;
        else                       return REGION_VRAM;
    endfunction

endpackage

// File: rtl/epochtv1_bus_strobe.sv
// CE-aligned single write cycle generator for the epochtv1 CPU port.
// Latency: strobe visible the CLK after the granting CE, released on the next CE.
// Backpressure: req_i is held until gnt_o; ack_o marks the releasing CE CLK.
module epochtv1_bus_strobe
    import epochtv1_pkg::*;
#(
    parameter logic [12:0] RST_ADDR = 13'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic        req_i,
    input  logic [12:0] addr_i,
    input  logic [7:0]  data_i,
    output logic        gnt_o,
    output logic        ack_o,
    output logic [12:0] a_o,
    output logic [7:0]  db_o,
    output logic        wrb_o,
    output logic        csb_o
);

    bs_state_e   state_q;
    logic [12:0] a_q;
    logic [7:0]  db_q;
    logic        wrb_q;
    logic        csb_q;

    // Handshake back to the requester: start and end of the write cycle
    assign gnt_o = (state_q == BS_IDLE)   && req_i && ce_i;
    assign ack_o = (state_q == BS_STROBE) && ce_i;

    // Write cycle FSM: assert on a CE, release on the next CE; A/DB_O are
    // left untouched at release so they outlive the strobe by at least a CLK
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BS_IDLE;
            a_q     <= RST_ADDR;
            db_q    <= 8'h00;
            wrb_q   <= 1'b1;
            csb_q   <= 1'b1;
        end else begin
            case (state_q)
                BS_IDLE: begin
                    if (req_i && ce_i) begin
                        a_q     <= addr_i;
                        db_q    <= data_i;
                        wrb_q   <= 1'b0;
                        csb_q   <= 1'b0;
                        state_q <= BS_STROBE;
                    end
                end
                BS_STROBE: begin
                    if (ce_i) begin
                        wrb_q   <= 1'b1;
                        csb_q   <= 1'b1;
                        state_q <= BS_IDLE;
                    end
                end
                default: state_q <= BS_IDLE;
            endcase
        end
    end

    assign a_o   = a_q;
    assign db_o  = db_q;
    assign wrb_o = wrb_q;
    assign csb_o = csb_q;

endmodule

// File: rtl/epochtv1_state_loader.sv
// Restores an Epoch TV-1 state image by writing a byte stream into the chip port.
// Latency: min 2 CE periods per byte (one held strobe, one CE gap); DONE on last release.
// Backpressure: IN_READY only in FETCH; a missing byte stalls with the bus idle.
// Optional: EPOCHTV1_STATE_LOADER_CHECKSUM_EN adds an 8-bit CHECKSUM output.
module epochtv1_state_loader
    import epochtv1_pkg::*;
#(
    parameter int unsigned LEN  = 32'(IMAGE_LEN),
    parameter logic [12:0] BASE = VRAM_BASE
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic        START,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [12:0] A,
    output logic [7:0]  DB_O,
    output logic        WRB,
    output logic        RDB,
    output logic        CSB,
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
    output logic [7:0]  CHECKSUM,
`endif
    output logic        BUSY,
    output logic        DONE
);

    // Index of the final byte; LEN up to 8192 still fits the 13-bit counter
    localparam logic [12:0] LAST_IDX = 13'(LEN - 1);

    ld_state_e   state_q;
    logic [12:0] idx_q;
    logic [7:0]  hold_q;
    logic        in_ready_q;
    logic        busy_q;
    logic        done_q;
    logic [12:0] addr_d;
    logic        req;
    logic        gnt;
    logic        ack;
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
    logic [7:0]  checksum_q;
`endif

    // Target address of the byte currently held
    assign addr_d = image_addr(BASE, idx_q);
    assign req    = (state_q == LD_ARM);

    epochtv1_bus_strobe #(
        .RST_ADDR (BASE)
    ) u_strobe (
        .clk_i  (CLK),
        .rst_i  (RES),
        .ce_i   (CE),
        .req_i  (req),
        .addr_i (addr_d),
        .data_i (hold_q),
        .gnt_o  (gnt),
        .ack_o  (ack),
        .a_o    (A),
        .db_o   (DB_O),
        .wrb_o  (WRB),
        .csb_o  (CSB)
    );

    // Loader FSM: START begins a load, each byte is fetched then handed to
    // the strobe generator; the byte accepted this CLK is only requested from
    // the next CLK, so a coincident CE cannot start its strobe early
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q    <= LD_IDLE;
            idx_q      <= 13'd0;
            hold_q     <= 8'h00;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
            checksum_q <= 8'h00;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    if (START) begin
                        state_q    <= LD_FETCH;
                        idx_q      <= 13'd0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
                        checksum_q <= 8'h00;
`endif
                    end
                end
                LD_FETCH: begin
                    if (IN_VALID && in_ready_q) begin
                        hold_q     <= IN_DATA;
                        in_ready_q <= 1'b0;
                        state_q    <= LD_ARM;
                    end
                end
                LD_ARM: begin
                    if (gnt) begin
                        state_q <= LD_STROBE;
                    end
                end
                LD_STROBE: begin
                    if (ack) begin
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
                        checksum_q <= checksum_q + hold_q;
`endif
                        if (idx_q == LAST_IDX) begin
                            state_q <= LD_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q      <= idx_q + 13'd1;
                            in_ready_q <= 1'b1;
                            state_q    <= LD_FETCH;
                        end
                    end
                end
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    assign IN_READY = in_ready_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RDB      = 1'b1;
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
    assign CHECKSUM = checksum_q;
`endif

endmodule

// File: tb/tb_epochtv1_state_loader.sv
// Directed bench for epochtv1_state_loader: two instances (LEN=3/BASE=0x1400
// and LEN=8/BASE=0x1FFF) share CLK and a CE that pulses every 4th CLK.
// Bus activity is logged at falling CLK edges and checked against fixed vectors.
module tb_epochtv1_state_loader;

    logic CLK = 1'b0;
    logic CE  = 1'b0;
    always #5 CLK = ~CLK;

    // CE: one CLK high in every four, changed away from the active edge
    initial begin
        forever begin
            repeat (3) @(negedge CLK);
            CE = 1'b1;
            @(negedge CLK);
            CE = 1'b0;
        end
    end

    int ce_cnt = 0;
    always @(posedge CLK) if (CE) ce_cnt <= ce_cnt + 1;

    // Instance a
    logic        RES_a = 1'b1, START_a = 1'b0, IN_VALID_a = 1'b0;
    logic [7:0]  IN_DATA_a = 8'h00;
    logic        IN_READY_a, WRB_a, RDB_a, CSB_a, BUSY_a, DONE_a;
    logic [12:0] A_a;
    logic [7:0]  DB_O_a;
    // Instance b
    logic        RES_b = 1'b1, START_b = 1'b0, IN_VALID_b = 1'b0;
    logic [7:0]  IN_DATA_b = 8'h00;
    logic        IN_READY_b, WRB_b, RDB_b, CSB_b, BUSY_b, DONE_b;
    logic [12:0] A_b;
    logic [7:0]  DB_O_b;
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
    logic [7:0]  CHECKSUM_a, CHECKSUM_b;
`endif

    epochtv1_state_loader #(.LEN(3), .BASE(13'h1400)) u_a (
        .CLK(CLK), .RES(RES_a), .CE(CE), .START(START_a),
        .IN_DATA(IN_DATA_a), .IN_VALID(IN_VALID_a), .IN_READY(IN_READY_a),
        .A(A_a), .DB_O(DB_O_a), .WRB(WRB_a), .RDB(RDB_a), .CSB(CSB_a),
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
        .CHECKSUM(CHECKSUM_a),
`endif
        .BUSY(BUSY_a), .DONE(DONE_a)
    );

    epochtv1_state_loader #(.LEN(8), .BASE(13'h1FFF)) u_b (
        .CLK(CLK), .RES(RES_b), .CE(CE), .START(START_b),
        .IN_DATA(IN_DATA_b), .IN_VALID(IN_VALID_b), .IN_READY(IN_READY_b),
        .A(A_b), .DB_O(DB_O_b), .WRB(WRB_b), .RDB(RDB_b), .CSB(CSB_b),
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
        .CHECKSUM(CHECKSUM_b),
`endif
        .BUSY(BUSY_b), .DONE(DONE_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-pulse logs: address/data at assertion, length in CE periods
    logic [12:0] a_addr[$], b_addr[$];
    logic [7:0]  a_data[$], b_data[$];
    int          a_dur[$],  b_dur[$];
    int a_start = 0, b_start = 0, a_unstable = 0, b_unstable = 0;
    int a_csb_err = 0, b_csb_err = 0, a_done = 0, b_done = 0;
    int a_done_busy = 0, b_done_busy = 0;
    logic a_prev = 1'b1, b_prev = 1'b1;

    always @(negedge CLK) begin
        if (!WRB_a && a_prev) begin
            a_addr.push_back(A_a); a_data.push_back(DB_O_a); a_start = ce_cnt;
        end else if (!WRB_a && (A_a !== a_addr[$] || DB_O_a !== a_data[$])) begin
            a_unstable++;
        end
        if (WRB_a && !a_prev) begin
            a_dur.push_back(ce_cnt - a_start);
            if (!RES_a && (A_a !== a_addr[$] || DB_O_a !== a_data[$])) a_unstable++;
        end
        if (CSB_a !== WRB_a) a_csb_err++;
        if (DONE_a) begin a_done++; if (BUSY_a) a_done_busy++; end
        a_prev = WRB_a;
    end

    always @(negedge CLK) begin
        if (!WRB_b && b_prev) begin
            b_addr.push_back(A_b); b_data.push_back(DB_O_b); b_start = ce_cnt;
        end else if (!WRB_b && (A_b !== b_addr[$] || DB_O_b !== b_data[$])) begin
            b_unstable++;
        end
        if (WRB_b && !b_prev) begin
            b_dur.push_back(ce_cnt - b_start);
            if (!RES_b && (A_b !== b_addr[$] || DB_O_b !== b_data[$])) b_unstable++;
        end
        if (CSB_b !== WRB_b) b_csb_err++;
        if (DONE_b) begin b_done++; if (BUSY_b) b_done_busy++; end
        b_prev = WRB_b;
    end

    task automatic pulse_start(input bit b);
        if (b) START_b = 1'b1; else START_a = 1'b1;
        @(negedge CLK);
        START_a = 1'b0; START_b = 1'b0;
    endtask

    // Present one byte and return at the falling edge after it is accepted
    task automatic send(input bit b, input logic [7:0] d);
        int t = 0;
        if (b) begin IN_DATA_b = d; IN_VALID_b = 1'b1; end
        else   begin IN_DATA_a = d; IN_VALID_a = 1'b1; end
        while (!(b ? IN_READY_b : IN_READY_a) && t < 400) begin
            @(negedge CLK); t++;
        end
        chk(b ? "in_ready_b" : "in_ready_a", b ? IN_READY_b : IN_READY_a, 1);
        @(negedge CLK);
    endtask

    task automatic wait_done(input bit b);
        int t = 0;
        while (!(b ? DONE_b : DONE_a) && t < 400) begin
            @(negedge CLK); t++;
        end
        chk(b ? "done_b_seen" : "done_a_seen", b ? DONE_b : DONE_a, 1);
        chk(b ? "busy_b_at_done" : "busy_a_at_done", b ? BUSY_b : BUSY_a, 0);
    endtask

    logic [12:0] exp_a_addr [6] = '{13'h1400, 13'h1401, 13'h1402, 13'h1400, 13'h1401, 13'h1402};
    logic [7:0]  exp_a_data [6] = '{8'h11, 8'h22, 8'h33, 8'hFF, 8'h02, 8'h10};

    initial begin
        int t;
        int stall_low;

        // Reset values, and START coincident with RES is ignored
        repeat (2) @(negedge CLK);
        chk("rst_A", A_a, 13'h1400);
        chk("rst_DB_O", DB_O_a, 8'h00);
        chk("rst_WRB", WRB_a, 1);
        chk("rst_RDB", RDB_a, 1);
        chk("rst_CSB", CSB_a, 1);
        chk("rst_IN_READY", IN_READY_a, 0);
        chk("rst_BUSY", BUSY_a, 0);
        chk("rst_DONE", DONE_a, 0);
        chk("rst_A_b", A_b, 13'h1FFF);
        pulse_start(1'b0);
        chk("start_in_reset_busy", BUSY_a, 0);
        RES_a = 1'b0; RES_b = 1'b0;
        repeat (3) @(negedge CLK);
        chk("start_in_reset_after", BUSY_a, 0);

        // Three-byte image, IN_VALID held high throughout
        pulse_start(1'b0);
        chk("load1_busy", BUSY_a, 1);
        chk("load1_in_ready", IN_READY_a, 1);
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        wait_done(1'b0);
        chk("load1_wrb_at_done", WRB_a, 1);
        IN_VALID_a = 1'b0;
        repeat (4) @(negedge CLK);
        chk("load1_writes", a_addr.size(), 3);
        chk("load1_done_cnt", a_done, 1);
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
        chk("load1_checksum", CHECKSUM_a, 8'h66);
`endif

        // Second load with a 50-CE stall between byte 1 and byte 2
        pulse_start(1'b0);
        send(1'b0, 8'hFF);
        IN_VALID_a = 1'b0;
        t = 0;
        while (!IN_READY_a && t < 400) begin @(negedge CLK); t++; end
        chk("stall_fetch_reached", IN_READY_a, 1);
        stall_low = 0;
        repeat (200) begin
            @(negedge CLK);
            if (!WRB_a || !CSB_a) stall_low++;
        end
        chk("stall_bus_idle", stall_low, 0);
        chk("stall_busy", BUSY_a, 1);
        send(1'b0, 8'h02);
        send(1'b0, 8'h10);
        IN_VALID_a = 1'b0;
        wait_done(1'b0);
`ifdef EPOCHTV1_STATE_LOADER_CHECKSUM_EN
        chk("checksum_at_done", CHECKSUM_a, 8'h11);
`endif
        repeat (4) @(negedge CLK);
        chk("a_writes_total", a_addr.size(), 6);
        chk("a_done_total", a_done, 2);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("a_addr%0d", i), a_addr[i], exp_a_addr[i]);
            chk($sformatf("a_data%0d", i), a_data[i], exp_a_data[i]);
            chk($sformatf("a_dur%0d", i), a_dur[i], 1);
        end
        chk("a_unstable", a_unstable, 0);
        chk("a_csb_follow", a_csb_err, 0);
        chk("a_done_busy", a_done_busy, 0);

        // Reset mid-strobe at idx=5 on the wrapping instance
        pulse_start(1'b1);
        for (int i = 0; i < 6; i++) send(1'b1, 8'hA0 + 8'(i));
        IN_VALID_b = 1'b0;
        t = 0;
        while (WRB_b && t < 400) begin @(negedge CLK); t++; end
        chk("b_strobe_idx5", WRB_b, 0);
        #2 RES_b = 1'b1;
        #1;
        chk("b_rst_WRB", WRB_b, 1);
        chk("b_rst_CSB", CSB_b, 1);
        chk("b_rst_BUSY", BUSY_b, 0);
        chk("b_rst_A", A_b, 13'h1FFF);
        repeat (3) @(negedge CLK);
        RES_b = 1'b0;
        @(negedge CLK);
        chk("b_abort_writes", b_addr.size(), 6);
        chk("b_abort_addr5", b_addr[5], 13'h0004);
        chk("b_abort_data5", b_data[5], 8'hA5);
        chk("b_abort_done", b_done, 0);

        // Full 8-byte restart with wrap and a START pulse while busy
        pulse_start(1'b1);
        for (int i = 0; i < 3; i++) send(1'b1, 8'hC0 + 8'(i));
        IN_VALID_b = 1'b0;
        pulse_start(1'b1);
        for (int i = 3; i < 8; i++) send(1'b1, 8'hC0 + 8'(i));
        IN_VALID_b = 1'b0;
        wait_done(1'b1);
        repeat (12) @(negedge CLK);
        chk("b_done_total", b_done, 1);
        chk("b_busy_after", BUSY_b, 0);
        chk("b_writes_total", b_addr.size(), 14);
        chk("b_wrap_addr0", b_addr[6], 13'h1FFF);
        chk("b_wrap_data0", b_data[6], 8'hC0);
        chk("b_wrap_addr1", b_addr[7], 13'h0000);
        chk("b_wrap_data1", b_data[7], 8'hC1);
        chk("b_last_addr", b_addr[13], 13'h0006);
        chk("b_last_data", b_data[13], 8'hC7);
        for (int i = 6; i < 14; i++) chk($sformatf("b_dur%0d", i), b_dur[i], 1);
        chk("b_unstable", b_unstable, 0);
        chk("b_csb_follow", b_csb_err, 0);
        chk("b_done_busy", b_done_busy, 0);
        chk("b_rdb", RDB_b, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
